// File: rtl/hdb3_pkg.sv
// Shared HDB3 line-code definitions used by the receive decoder and the matching encoder.
package hdb3_pkg;

  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_POS  = 2'b01;
  localparam logic [1:0] CODE_NEG  = 2'b10;
  localparam logic [1:0] CODE_ILL  = 2'b11;

  // A run of RUN_LEN zeros is replaced by a plug; bit 0 is the first symbol on the line.
  localparam int         RUN_LEN   = 4;
  localparam logic [3:0] PLUG_000V = 4'b1000;
  localparam logic [3:0] PLUG_B00V = 4'b1001;

  localparam int DEC_LAT = 4;

  typedef enum logic [1:0] {
    SYM_ZERO = 2'b00,
    SYM_POS  = 2'b01,
    SYM_NEG  = 2'b10,
    SYM_ILL  = 2'b11
  } sym_e;

  typedef struct packed {
    logic mark;
    logic viol;
  } vdet_t;

  function automatic logic is_mark(input logic [1:0] code,
                                   input logic [1:0] pos,
                                   input logic [1:0] neg);
    return (code == pos) || (code == neg);
  endfunction

endpackage

// File: rtl/hdb3_t2d_if.sv
// Symbol-in / NRZ-out bus between the line slicer, the HDB3 decoder and the framer.
interface hdb3_t2d_if;
  logic       i_code_vld;
  logic [1:0] i_hdb3_code;
  logic       o_data;
  logic       o_data_vld;
  logic       o_code_err;

  modport master (
    output i_code_vld,
    output i_hdb3_code,
    input  o_data,
    input  o_data_vld,
    input  o_code_err
  );

  modport slave (
    input  i_code_vld,
    input  i_hdb3_code,
    output o_data,
    output o_data_vld,
    output o_code_err
  );
endinterface

// File: rtl/hdb3_v_detect.sv
// Polarity tracking, V-pulse detection and registered line-rule error flag for the HDB3 decoder.
module hdb3_v_detect
  import hdb3_pkg::vdet_t, hdb3_pkg::is_mark;
#(
  parameter logic [1:0] CODE_POS = hdb3_pkg::CODE_POS,
  parameter logic [1:0] CODE_NEG = hdb3_pkg::CODE_NEG,
  parameter bit         CHECK_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       code_vld_i,
  input  logic [1:0] code_i,
  output vdet_t      det_o,
  output logic       code_err_o
);

  logic       last_pol_q;
  logic       last_v_pol_q;
  logic       seen_mark_q;
  logic       seen_v_q;
  logic [1:0] raw_q;
  logic       err_q;

  logic mark;
  logic pol;
  logic viol;
  logic ill;
  logic err_d;

  always_comb begin
    mark = is_mark(code_i, CODE_POS, CODE_NEG);
    pol  = (code_i == CODE_POS);
    viol = mark && seen_mark_q && (pol == last_pol_q);
    ill  = (code_i == hdb3_pkg::CODE_ILL);
    // Any one of: illegal symbol, two V pulses in a row of one polarity, V too close to a mark.
    err_d = 1'b0;
    if (CHECK_EN) begin
      err_d = code_vld_i && (ill ||
                             (viol && seen_v_q && (pol == last_v_pol_q)) ||
                             (viol && (|raw_q)));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_pol_q   <= 1'b0;
      last_v_pol_q <= 1'b0;
      seen_mark_q  <= 1'b0;
      seen_v_q     <= 1'b0;
      raw_q        <= 2'b00;
      err_q        <= 1'b0;
    end else begin
      err_q <= err_d;
      if (code_vld_i) begin
        raw_q <= {raw_q[0], mark};
        if (mark) begin
          last_pol_q  <= pol;
          seen_mark_q <= 1'b1;
        end
        if (viol) begin
          last_v_pol_q <= pol;
          seen_v_q     <= 1'b1;
        end
      end
    end
  end

  assign det_o.mark = mark;
  assign det_o.viol = viol;
  assign code_err_o = err_q;

endmodule

// File: rtl/hdb3_t2d.sv
// HDB3 receive decoder: strips V and paired B pulses and emits NRZ data a fixed four symbols late.
module hdb3_t2d
  import hdb3_pkg::DEC_LAT, hdb3_pkg::vdet_t;
#(
  parameter logic [1:0] CODE_POS = hdb3_pkg::CODE_POS,
  parameter logic [1:0] CODE_NEG = hdb3_pkg::CODE_NEG,
  parameter bit         CHECK_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  hdb3_t2d_if.slave  bus
);

  logic [3:0] sr_q,   sr_d;
  logic [2:0] fill_q, fill_d;
  logic       vld_q,  vld_d;
  vdet_t      det;
  logic       code_err;

  hdb3_v_detect #(
    .CODE_POS (CODE_POS),
    .CODE_NEG (CODE_NEG),
    .CHECK_EN (CHECK_EN)
  ) u_v_detect (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .code_vld_i (bus.i_code_vld),
    .code_i     (bus.i_hdb3_code),
    .det_o      (det),
    .code_err_o (code_err)
  );

  always_comb begin
    // A V is written as zero and knocks out the slot three symbols back, where its B would sit.
    sr_d   = {sr_q[2] & ~det.viol, sr_q[1], sr_q[0], det.mark & ~det.viol};
    fill_d = (fill_q == 3'(DEC_LAT)) ? fill_q : fill_q + 3'd1;
    vld_d  = bus.i_code_vld && (fill_d == 3'(DEC_LAT));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr_q   <= 4'b0000;
      fill_q <= 3'd0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (bus.i_code_vld) begin
        sr_q   <= sr_d;
        fill_q <= fill_d;
      end
    end
  end

  assign bus.o_data     = sr_q[3];
  assign bus.o_data_vld = vld_q;
  assign bus.o_code_err = code_err;

endmodule

// File: tb/tb_hdb3_t2d.sv
// Scoreboard bench for hdb3_t2d: directed plug patterns, error injection, stalls, reset and an encoded random stream.
module tb_hdb3_t2d;

  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] I = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hdb3_t2d_if bus();

  hdb3_t2d #(
    .CODE_POS (2'b01),
    .CODE_NEG (2'b10),
    .CHECK_EN (1'b1)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  int    acc   = 0;
  string tag   = "init";
  bit    dq[$];
  bit    vq[$];
  bit    eq[$];

  // One symbol per cycle; expected results are queued as the stimulus is applied.
  task automatic drive(input logic [1:0] c, input bit v, input bit eb, input bit ee);
    @(negedge clk);
    bus.i_hdb3_code = c;
    bus.i_code_vld  = v;
    if (v) begin
      acc++;
      dq.push_back(eb);
    end
    vq.push_back(v && (acc >= 4));
    eq.push_back(v && ee);
  endtask

  always @(posedge clk) begin
    bit ev, ee, ed;
    #1;
    if (vq.size() > 0) begin
      ev = vq.pop_front();
      ee = eq.pop_front();
      n_cmp++;
      if (bus.o_data_vld !== ev) begin
        n_bad++;
        $display("FAIL %s data_vld: got %b expected %b at %0t", tag, bus.o_data_vld, ev, $time);
      end
      n_cmp++;
      if (bus.o_code_err !== ee) begin
        n_bad++;
        $display("FAIL %s code_err: got %b expected %b at %0t", tag, bus.o_code_err, ee, $time);
      end
      if (ev) begin
        n_cmp++;
        if (dq.size() == 0) begin
          n_bad++;
          $display("FAIL %s data: got %b expected nothing (queue empty) at %0t", tag, bus.o_data, $time);
        end else begin
          ed = dq.pop_front();
          if (bus.o_data !== ed) begin
            n_bad++;
            $display("FAIL %s data: got %b expected %b at %0t", tag, bus.o_data, ed, $time);
          end
        end
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    bus.i_code_vld  = 1'b0;
    bus.i_hdb3_code = Z;
    rst_n = 1'b0;
    #1;
    dq.delete();
    vq.delete();
    eq.delete();
    acc = 0;
    n_cmp++;
    if (bus.o_data !== 1'b0) begin
      n_bad++;
      $display("FAIL %s reset o_data: got %b expected 0", tag, bus.o_data);
    end
    n_cmp++;
    if (bus.o_data_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL %s reset o_data_vld: got %b expected 0", tag, bus.o_data_vld);
    end
    n_cmp++;
    if (bus.o_code_err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s reset o_code_err: got %b expected 0", tag, bus.o_code_err);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_000v();
    logic [1:0] c[9] = '{N, Z, Z, Z, N, Z, Z, Z, Z};
    bit         b[9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tag = "000v";
    test_reset();
    for (int k = 0; k < 9; k++) drive(c[k], 1'b1, b[k], 1'b0);
  endtask

  task automatic test_b00v();
    logic [1:0] c[10] = '{N, P, N, Z, Z, N, Z, Z, Z, Z};
    bit         b[10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tag = "b00v";
    test_reset();
    for (int k = 0; k < 10; k++) drive(c[k], 1'b1, b[k], 1'b0);
  endtask

  task automatic test_illegal();
    logic [1:0] c[9] = '{P, Z, I, Z, N, Z, Z, Z, Z};
    bit         b[9] = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
    bit         e[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    tag = "illegal";
    test_reset();
    for (int k = 0; k < 9; k++) drive(c[k], 1'b1, b[k], e[k]);
  endtask

  task automatic test_v_repeat();
    logic [1:0] c[14] = '{N, Z, Z, Z, N, P, N, Z, Z, N, Z, Z, Z, Z};
    bit         b[14] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    bit         e[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tag = "v_repeat";
    test_reset();
    for (int k = 0; k < 14; k++) drive(c[k], 1'b1, b[k], e[k]);
  endtask

  task automatic test_early_v();
    logic [1:0] c[7] = '{P, N, N, Z, Z, Z, Z};
    bit         b[7] = '{1, 1, 0, 0, 0, 0, 0};
    bit         e[7] = '{0, 0, 1, 0, 0, 0, 0};
    tag = "early_v";
    test_reset();
    for (int k = 0; k < 7; k++) drive(c[k], 1'b1, b[k], e[k]);
  endtask

  task automatic test_stream();
    bit         d[$];
    logic [1:0] s[$];
    bit         lastp;
    int         ones;
    int         i;
    tag = "stream";
    test_reset();
    for (int ch = 0; ch < 8; ch++) begin
      for (int k = 0; k < 24; k++) d.push_back(1'($urandom_range(0, 1)));
      for (int k = 0; k < 16; k++) d.push_back(1'b0);
    end
    for (int k = 0; k < 4; k++) d.push_back(1'b0);
    lastp = 1'b0;
    ones  = 0;
    i     = 0;
    while (i < d.size()) begin
      if ((i + 3 < d.size()) && !d[i] && !d[i+1] && !d[i+2] && !d[i+3]) begin
        if (ones % 2 == 1) begin
          s.push_back(Z); s.push_back(Z); s.push_back(Z);
          s.push_back(lastp ? P : N);
        end else begin
          lastp = ~lastp;
          s.push_back(lastp ? P : N);
          s.push_back(Z); s.push_back(Z);
          s.push_back(lastp ? P : N);
        end
        ones = 0;
        i += 4;
      end else if (d[i]) begin
        lastp = ~lastp;
        s.push_back(lastp ? P : N);
        ones++;
        i++;
      end else begin
        s.push_back(Z);
        i++;
      end
    end
    for (int k = 0; k < s.size(); k++) drive(s[k], 1'b1, d[k], 1'b0);
  endtask

  task automatic test_stall_reset();
    logic [1:0] c[6] = '{P, Z, N, Z, Z, P};
    bit         b[6] = '{1, 0, 1, 0, 0, 1};
    logic [1:0] r[6] = '{P, Z, Z, N, Z, Z};
    bit         rb[6] = '{1, 0, 0, 1, 0, 0};
    tag = "stall";
    test_reset();
    for (int k = 0; k < 6; k++) drive(c[k], 1'b1, b[k], 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(I, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.o_data !== 1'b1) begin
        n_bad++;
        $display("FAIL %s held o_data: got %b expected 1", tag, bus.o_data);
      end
    end
    drive(Z, 1'b1, 1'b0, 1'b0);
    drive(Z, 1'b1, 1'b0, 1'b0);
    tag = "midreset";
    @(negedge clk);
    bus.i_code_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    dq.delete();
    vq.delete();
    eq.delete();
    acc = 0;
    n_cmp++;
    if ({bus.o_data, bus.o_data_vld, bus.o_code_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL %s outputs: got %b expected 000", tag,
               {bus.o_data, bus.o_data_vld, bus.o_code_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) drive(r[k], 1'b1, rb[k], 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.i_code_vld  = 1'b0;
    bus.i_hdb3_code = Z;
    tag = "reset";
    test_reset();
    test_000v();
    test_b00v();
    test_illegal();
    test_v_repeat();
    test_early_v();
    test_stream();
    test_stall_reset();
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hdb3_t2d.md
Name: hdb3_t2d

Overview:
HDB3 receive-side decoder. Accepts one bipolar ternary symbol per enabled clock in the team's 2-bit line encoding: 01 = +1, 10 = -1, 00 = 0, 11 = illegal. Detects violation (V) pulses and their paired bipolar-violation (B) pulses, strips them, and emits the recovered NRZ bit stream after a fixed 4-symbol delay. Sits at the receiver front end, after line slicing, ahead of framing and deframing logic.

Parameters:
CODE_POS, 2'b01, symbol encoding for a +1 pulse.
CODE_NEG, 2'b10, symbol encoding for a -1 pulse.
CHECK_EN, 1, when 1, enables the line-rule error checks; when 0, o_code_err is tied to 0.

Ports:
i_clk  input  1  clock.
i_rst_n  input  1  reset, asynchronous, active-low.
i_code_vld  input  1  qualifies i_hdb3_code; when low, all state holds.
i_hdb3_code  input  2  bipolar symbol (CODE_POS / CODE_NEG / 00 / 11).
o_data  output  1  decoded NRZ bit.
o_data_vld  output  1  o_data carries a real decoded bit.
o_code_err  output  1  one-cycle line-rule violation pulse.

Behaviour:
- Reset values: all outputs 0, shift register 4'b0, fill counter 0, last-mark polarity 0, last-V polarity 0, seen-mark flag 0, seen-V flag 0.
- All state advances only on clocks with i_code_vld=1. An "accepted symbol" is a symbol presented on such a clock.
- mark = accepted symbol is CODE_POS or CODE_NEG. Symbols 11 and 00 are treated as zero for the data path.
- V detection: V = mark AND seen-mark AND (polarity equals last-mark polarity).
  - The first mark after reset is never a V.
  - Last-mark polarity updates on every mark, including V and B pulses.
- Data path: 4-bit shift register sr, where sr[0] is the newest entry and sr[2] is the symbol 3 positions before the current one.
  - Each accepted symbol: sr <= {sr[2] & ~V, sr[1], sr[0], mark & ~V}.
  - On V, the current symbol is written as 0 and the B slot (sr[2] on its way to sr[3]) is cleared.
  - o_data = sr[3], so latency is exactly 4 accepted symbols.
- Fill: a 3-bit counter saturates at 4. o_data_vld=1 once 4 symbols have been accepted since reset, and only on cycles where the shift occurred. o_data_vld is registered together with sr, so it pulses once per accepted symbol thereafter.
- Errors (CHECK_EN=1). o_code_err is registered and asserts the cycle after the offending accepted symbol. Causes:
  - symbol 11;
  - V whose polarity equals last-V polarity while seen-V=1 (V pulses must alternate);
  - V while sr[0] or sr[1] holds a raw mark; a raw-mark history of 2 bits is tracked separately from sr for this check.
  - Errors do not alter decoding.
- i_code_vld low: sr, counters, and polarity state hold. o_data holds. o_data_vld=0, o_code_err=0.
- Reset asserted mid-stream: immediate clear to reset values. The pipeline refills and o_data_vld stays 0 for the next 4 accepted symbols.
- V detected while fewer than 3 symbols are in sr: clear whatever occupies sr[2] (a zero after reset). No special case.

Decomposition:
- Shared package hdb3_pkg: symbol constants (CODE_POS, CODE_NEG, CODE_ZERO, CODE_ILL), plug-B constants shared with the encoder side, and the decode delay constant DEC_LAT = 4.
- Optional sub-module hdb3_v_detect: polarity tracking, V flag, and error checks. The datapath shift register stays in the top module.

Test Plan:
- Reset, then codes 10,00,00,00,10 with i_code_vld=1 continuous, then zeros -> o_data sequence 1,0,0,0,0 starting 4 accepted symbols after the first code; o_data_vld rises on the 4th accepted symbol; o_code_err=0.
- Codes 10,01,10,00,00,10 (B00V) -> o_data 1,1,0,0,0,0; the B at position 3 is removed; no error.
- Long stream from the matching encoder, random data plus runs of 16 zeros -> o_data matches source data delayed by 4; o_code_err never asserts.
- Inject symbol 11 mid-stream -> o_code_err=1 for exactly one cycle after it; the symbol decodes as 0.
- Two successive V pulses of the same polarity (10,00,00,00,10, then 01,10,00,00,10 arranged so V repeats -) -> o_code_err pulse after the second V.
- Toggle i_code_vld low for 3 cycles mid-stream, then assert i_rst_n low for 1 cycle -> outputs hold with o_data_vld=0 while stalled; after reset all outputs are 0 and o_data_vld stays 0 for the next 4 accepted symbols.
